// File: rtl/uart_tx_drain_pkg.sv
// Shared definitions for the UART transmit path: the frame FSM encoding,
// default timing parameters and the frame-length helper. The future
// receive side is expected to import this package as well.
package uart_tx_drain_pkg;

    // 2-bit encoding for the frame FSM (IDLE=0, START=1, DATA=2, STOP=3)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DEFAULT_BITS        = 8;
    localparam int DEFAULT_CLK_PER_BIT = 868;  // 100 MHz / 115200 baud
    localparam int DEFAULT_CNT_WIDTH   = 10;

    // Cycles after reset release during which the FIFO empty flag is not trusted
    localparam int HOLDOFF_CYCLES = 2;

    // Bit periods in one 8N1 frame: start + data bits + stop
    function automatic int frame_bits(input int bits);
        return bits + 2;
    endfunction

    localparam int FRAME_BITS = frame_bits(DEFAULT_BITS);

endpackage

// File: rtl/uart_tx_drain_if.sv
// Handshake bundle between the byte FIFO, the transmit drain and the line.
// The master modport is the drain itself: it owns the pop strobe and the
// serial outputs; the slave modport is the FIFO/line side.
interface uart_tx_drain_if
    import uart_tx_drain_pkg::*;
#(
    parameter int Bits = DEFAULT_BITS
);

    logic            fifo_empty;
    logic [Bits-1:0] fifo_dout;
    logic            fifo_rd;
    logic            tx;
    logic            tx_busy;
    logic            tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd,
        output tx,
        output tx_busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

endinterface

// File: rtl/uart_tx_drain_baud_counter.sv
// Bit-period counter. Counts 0..ClkPerBit-1 and wraps, raising bit_tick
// during the last cycle of each bit period. 'clear' holds it at zero so a
// new frame always starts on a fresh bit boundary.
module uart_baud_counter
    import uart_tx_drain_pkg::*;
#(
    parameter int ClkPerBit = DEFAULT_CLK_PER_BIT,
    parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_tick
);

    localparam logic [CntWidth-1:0] LastCount = CntWidth'(ClkPerBit - 1);

    // A one-cycle bit period would let the FSM re-sample the FIFO before
    // its empty flag reflects the pop, so reject it at elaboration.
    if (ClkPerBit < 2) begin : g_bad_clk_per_bit
        $error("uart_baud_counter: ClkPerBit must be at least 2");
    end

    if ((2 ** CntWidth) <= ClkPerBit) begin : g_bad_cnt_width
        $error("uart_baud_counter: CntWidth too narrow for ClkPerBit");
    end

    logic [CntWidth-1:0] count;

    // Free-running bit-period count, wrapping on every bit boundary
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LastCount) begin
            count <= '0;
        end else begin
            count <= count + CntWidth'(1);
        end
    end

    assign bit_tick = (count == LastCount);

endmodule

// File: rtl/uart_tx_drain.sv
// Transmit drain: pops bytes from the FIFO one at a time and shifts each
// out as an 8N1 frame (start, data LSB first, stop). The line idles high,
// the pop strobe fires exactly once per frame and only when the FIFO
// reports data, and the empty flag is ignored for a short holdoff after
// reset while the FIFO initialises.
module uart_tx_drain
    import uart_tx_drain_pkg::*;
#(
    parameter int Bits      = DEFAULT_BITS,
    parameter int ClkPerBit = DEFAULT_CLK_PER_BIT,
    parameter int CntWidth  = DEFAULT_CNT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    uart_tx_drain_if.master bus
);

    localparam int                  IdxWidth    = (Bits > 1) ? $clog2(Bits) : 1;
    localparam logic [IdxWidth-1:0] LastIdx     = IdxWidth'(Bits - 1);
    localparam logic [1:0]          HoldoffDone = 2'(HOLDOFF_CYCLES);

    tx_state_t           state, state_next;
    logic [Bits-1:0]     shift_reg, shift_next;
    logic [IdxWidth-1:0] bit_idx, bit_idx_next;
    logic [1:0]          holdoff_cnt, holdoff_next;
    logic                tx_reg, tx_next;
    logic                rd_reg, rd_next;
    logic                busy_reg, busy_next;
    logic                done_reg, done_next;
    logic                holdoff_done;
    logic                baud_clear;
    logic                bit_tick;

    assign holdoff_done = (holdoff_cnt == HoldoffDone);

    // Keeping the counter cleared while idle makes the start bit begin a full period
    assign baud_clear = (state == IDLE);

    uart_baud_counter #(
        .ClkPerBit (ClkPerBit),
        .CntWidth  (CntWidth)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .clear    (baud_clear),
        .bit_tick (bit_tick)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-output logic; all outputs are registered so the
    // pop strobe, line and busy flag change together on the frame-start edge
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx;
        tx_next      = tx_reg;
        rd_next      = 1'b0;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        holdoff_next = holdoff_done ? holdoff_cnt : holdoff_cnt + 2'd1;

        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (holdoff_done && !bus.fifo_empty) begin
                    shift_next   = bus.fifo_dout;
                    bit_idx_next = '0;
                    rd_next      = 1'b1;
                    tx_next      = 1'b0;
                    busy_next    = 1'b1;
                    state_next   = START;
                end
            end
            START: begin
                if (bit_tick) begin
                    tx_next      = shift_reg[0];
                    bit_idx_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_idx == LastIdx) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_next[0];
                        bit_idx_next = bit_idx + IdxWidth'(1);
                    end
                end
            end
            STOP: begin
                if (bit_tick) begin
                    tx_next    = 1'b1;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset drops any in-flight byte and restarts the holdoff
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_idx     <= '0;
            holdoff_cnt <= '0;
            tx_reg      <= 1'b1;
            rd_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            shift_reg   <= shift_next;
            bit_idx     <= bit_idx_next;
            holdoff_cnt <= holdoff_next;
            tx_reg      <= tx_next;
            rd_reg      <= rd_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    assign bus.tx      = tx_reg;
    assign bus.fifo_rd = rd_reg;
    assign bus.tx_busy = busy_reg;
    assign bus.tx_done = done_reg;

endmodule
